reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- 16-entry × 16-bit general-purpose register file for the CPU datapath.
- Two combinational read ports and one clocked write port.
- A third combinational port echoes the contents of the register currently addressed by the write port, for write-back observation and debug.
- Sits between instruction decode (register addresses) and the ALU/write-back stage.

Parameters:
- DATA_WIDTH, 16, width of each register and all data ports.
- ADDR_WIDTH, 4, width of each register address.
- NUM_REGS, 16, number of registers; must equal 2**ADDR_WIDTH.
- RESET_VALUE, 16'h0000, value loaded into every register on reset.

Ports:
- Clock  input  1  single clock; all writes occur on its rising edge.
- Reset  input  1  asynchronous, active-high reset; clears all registers.
- read1  input  ADDR_WIDTH  address for read port 1.
- read2  input  ADDR_WIDTH  address for read port 2.
- write  input  ADDR_WIDTH  write address; also selects the dataWritten echo.
- WriteEn  input  1  write enable; high = commit dataToWrite on the next rising Clock edge.
- dataToWrite  input  DATA_WIDTH  write data.
- dataRead1  output  DATA_WIDTH  contents of register[read1].
- dataRead2  output  DATA_WIDTH  contents of register[read2].
- dataWritten  output  DATA_WIDTH  contents of register[write].

Behaviour:
- Storage: NUM_REGS registers of DATA_WIDTH bits, indexed 0..NUM_REGS-1. No register is hardwired; register 0 is writable like any other.
- Reset:
  - While Reset=1, every register is forced to RESET_VALUE immediately, with no dependency on Clock.
  - All three outputs therefore read RESET_VALUE within the same delta or combinational settle.
  - Writes are blocked while Reset is high.
- Write:
  - On a rising Clock edge with Reset=0 and WriteEn=1: register[write] <= dataToWrite.
  - WriteEn=0: no register changes.
  - Exactly one register is written per edge.
- Read:
  - Purely combinational, zero cycle latency.
  - dataRead1 = register[read1], dataRead2 = register[read2], dataWritten = register[write].
  - Outputs update whenever the addresses or the stored contents change.
- Read-during-write (same address):
  - No bypass. Before the edge, a read of the address being written returns the old value.
  - The new value appears on all ports addressing that register immediately after the edge.
- dataWritten:
  - Before the edge it shows the current (old) contents of register[write].
  - After a committed write it shows dataToWrite.
- Both read ports may address the same register and return identical data.
- Reset asserted mid-operation (including coincident with a write edge): reset wins and the register ends at RESET_VALUE.
- On deassertion of Reset, the first write takes effect on the next rising Clock edge with WriteEn=1.
- Address width always covers all NUM_REGS entries, so there is no out-of-range case. X/Z on an address yields X on the corresponding output; no other side effects.

Test Plan:
- Assert Reset for 5 time units with no clocks -> dataRead1 (read1=0), dataRead2 (read2=15) and dataWritten all read 16'h0000.
- Reset=0, write=13, dataToWrite=16'hFFFA, WriteEn=1, one rising Clock edge -> dataWritten=16'hFFFA; then read1=13 -> dataRead1=16'hFFFA, while read2=15 remains 16'h0000.
- WriteEn=0, write=2, dataToWrite=16'h1234, several edges -> register 2 and dataWritten stay 16'h0000.
- read1=read2=write=7, dataToWrite=16'hA5A5, WriteEn=1 -> both read ports show 16'h0000 before the edge and 16'hA5A5 after it.
- Write 16'hBEEF to register 0 and 16'hCAFE to register 15 -> read1=0 gives 16'hBEEF and read2=15 gives 16'hCAFE, confirming register 0 is writable.
- After writing several registers, pulse Reset between clock edges -> all registers read 16'h0000 asynchronously; a write edge during Reset has no effect.

Source files
------------

// File: rtl/reg_file_if.sv
// Register-file access bundle: two read ports, one write port and the
// write-address echo, grouped so decode and write-back can share one handle.
interface reg_file_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0] read1;
  logic [ADDR_WIDTH-1:0] read2;
  logic [ADDR_WIDTH-1:0] write;
  logic                  WriteEn;
  logic [DATA_WIDTH-1:0] dataToWrite;
  logic [DATA_WIDTH-1:0] dataRead1;
  logic [DATA_WIDTH-1:0] dataRead2;
  logic [DATA_WIDTH-1:0] dataWritten;

  modport master (
    output read1, read2, write, WriteEn, dataToWrite,
    input  dataRead1, dataRead2, dataWritten
  );

  modport slave (
    input  read1, read2, write, WriteEn, dataToWrite,
    output dataRead1, dataRead2, dataWritten
  );
endinterface

// File: rtl/reg_file.sv
// 16 x 16 general-purpose register file: two combinational read ports, one
// clocked write port, and a combinational echo of the write-addressed register.
module reg_file #(
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    ADDR_WIDTH  = 4,
  parameter int                    NUM_REGS    = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = 16'h0000
) (
  input  logic         Clock,
  input  logic         Reset,
  reg_file_if.slave    bus
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    if (bus.WriteEn) begin
      regs_d[bus.write] = bus.dataToWrite;
    end
  end

  // Asynchronous clear dominates any write edge that coincides with Reset.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VALUE;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Reads see stored state only: no write bypass.
  always_comb begin
    bus.dataRead1   = regs_q[bus.read1];
    bus.dataRead2   = regs_q[bus.read2];
    bus.dataWritten = regs_q[bus.write];
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file: reset, writes, write-disable,
// read-during-write, register 0/15 access, back-to-back writes, mid-run reset.
module tb_reg_file;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  logic clk_run = 1'b0;
  int   errors = 0;
  int   checks = 0;

  reg_file_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) bus ();

  reg_file #(
    .DATA_WIDTH (16),
    .ADDR_WIDTH (4),
    .NUM_REGS   (16),
    .RESET_VALUE(16'h0000)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus.slave)
  );

  always begin
    #5;
    if (clk_run) Clock = ~Clock;
  end

  task automatic test_reset;
    bus.read1 = 4'd0; bus.read2 = 4'd15; bus.write = 4'd3;
    bus.WriteEn = 1'b0; bus.dataToWrite = 16'h0000;
    #1 Reset = 1'b1;
    #5;
    checks++; if (bus.dataRead1 !== 16'h0000) begin errors++; $display("FAIL reset_rd1 got=%h exp=%h", bus.dataRead1, 16'h0000); end
    checks++; if (bus.dataRead2 !== 16'h0000) begin errors++; $display("FAIL reset_rd2 got=%h exp=%h", bus.dataRead2, 16'h0000); end
    checks++; if (bus.dataWritten !== 16'h0000) begin errors++; $display("FAIL reset_wr got=%h exp=%h", bus.dataWritten, 16'h0000); end
    Reset = 1'b0;
    clk_run = 1'b1;
    @(negedge Clock);
  endtask

  task automatic test_write_basic;
    bus.write = 4'd13; bus.dataToWrite = 16'hFFFA; bus.WriteEn = 1'b1;
    @(posedge Clock); #1;
    checks++; if (bus.dataWritten !== 16'hFFFA) begin errors++; $display("FAIL wr13_echo got=%h exp=%h", bus.dataWritten, 16'hFFFA); end
    bus.WriteEn = 1'b0;
    bus.read1 = 4'd13; bus.read2 = 4'd15;
    #1;
    checks++; if (bus.dataRead1 !== 16'hFFFA) begin errors++; $display("FAIL wr13_rd1 got=%h exp=%h", bus.dataRead1, 16'hFFFA); end
    checks++; if (bus.dataRead2 !== 16'h0000) begin errors++; $display("FAIL wr13_rd2_r15 got=%h exp=%h", bus.dataRead2, 16'h0000); end
    @(negedge Clock);
  endtask

  task automatic test_write_disable;
    bus.WriteEn = 1'b0; bus.write = 4'd2; bus.dataToWrite = 16'h1234;
    bus.read1 = 4'd2; bus.read2 = 4'd13;
    repeat (3) @(posedge Clock);
    #1;
    checks++; if (bus.dataWritten !== 16'h0000) begin errors++; $display("FAIL wen0_echo got=%h exp=%h", bus.dataWritten, 16'h0000); end
    checks++; if (bus.dataRead1 !== 16'h0000) begin errors++; $display("FAIL wen0_rd1 got=%h exp=%h", bus.dataRead1, 16'h0000); end
    checks++; if (bus.dataRead2 !== 16'hFFFA) begin errors++; $display("FAIL wen0_r13_kept got=%h exp=%h", bus.dataRead2, 16'hFFFA); end
    @(negedge Clock);
  endtask

  task automatic test_read_during_write;
    bus.read1 = 4'd7; bus.read2 = 4'd7; bus.write = 4'd7;
    bus.dataToWrite = 16'hA5A5; bus.WriteEn = 1'b1;
    #1;
    checks++; if (bus.dataRead1 !== 16'h0000) begin errors++; $display("FAIL rdw_pre_rd1 got=%h exp=%h", bus.dataRead1, 16'h0000); end
    checks++; if (bus.dataRead2 !== 16'h0000) begin errors++; $display("FAIL rdw_pre_rd2 got=%h exp=%h", bus.dataRead2, 16'h0000); end
    checks++; if (bus.dataWritten !== 16'h0000) begin errors++; $display("FAIL rdw_pre_echo got=%h exp=%h", bus.dataWritten, 16'h0000); end
    @(posedge Clock); #1;
    checks++; if (bus.dataRead1 !== 16'hA5A5) begin errors++; $display("FAIL rdw_post_rd1 got=%h exp=%h", bus.dataRead1, 16'hA5A5); end
    checks++; if (bus.dataRead2 !== 16'hA5A5) begin errors++; $display("FAIL rdw_post_rd2 got=%h exp=%h", bus.dataRead2, 16'hA5A5); end
    checks++; if (bus.dataWritten !== 16'hA5A5) begin errors++; $display("FAIL rdw_post_echo got=%h exp=%h", bus.dataWritten, 16'hA5A5); end
    bus.WriteEn = 1'b0;
    @(negedge Clock);
  endtask

  task automatic test_reg0_and_15;
    bus.WriteEn = 1'b1;
    bus.write = 4'd0;  bus.dataToWrite = 16'hBEEF;
    @(negedge Clock);
    bus.write = 4'd15; bus.dataToWrite = 16'hCAFE;
    @(negedge Clock);
    bus.WriteEn = 1'b0;
    bus.read1 = 4'd0; bus.read2 = 4'd15;
    #1;
    checks++; if (bus.dataRead1 !== 16'hBEEF) begin errors++; $display("FAIL reg0_rd1 got=%h exp=%h", bus.dataRead1, 16'hBEEF); end
    checks++; if (bus.dataRead2 !== 16'hCAFE) begin errors++; $display("FAIL reg15_rd2 got=%h exp=%h", bus.dataRead2, 16'hCAFE); end
    @(negedge Clock);
  endtask

  task automatic test_back_to_back;
    logic [15:0] vals [4];
    vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h4444; vals[3] = 16'h8888;
    bus.WriteEn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.write = 4'(i + 1); bus.dataToWrite = vals[i];
      @(negedge Clock);
    end
    bus.WriteEn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.read1 = 4'(i + 1);
      #1;
      checks++; if (bus.dataRead1 !== vals[i]) begin errors++; $display("FAIL b2b_r%0d got=%h exp=%h", i + 1, bus.dataRead1, vals[i]); end
    end
    @(negedge Clock);
  endtask

  task automatic test_reset_mid;
    bus.read1 = 4'd13; bus.read2 = 4'd7; bus.write = 4'd0; bus.WriteEn = 1'b0;
    #1 Reset = 1'b1;
    #1;
    checks++; if (bus.dataRead1 !== 16'h0000) begin errors++; $display("FAIL rstmid_rd1 got=%h exp=%h", bus.dataRead1, 16'h0000); end
    checks++; if (bus.dataRead2 !== 16'h0000) begin errors++; $display("FAIL rstmid_rd2 got=%h exp=%h", bus.dataRead2, 16'h0000); end
    checks++; if (bus.dataWritten !== 16'h0000) begin errors++; $display("FAIL rstmid_echo got=%h exp=%h", bus.dataWritten, 16'h0000); end
    bus.write = 4'd5; bus.dataToWrite = 16'h5555; bus.WriteEn = 1'b1;
    @(posedge Clock); #1;
    checks++; if (bus.dataWritten !== 16'h0000) begin errors++; $display("FAIL rst_blocks_wr got=%h exp=%h", bus.dataWritten, 16'h0000); end
    @(negedge Clock);
    bus.WriteEn = 1'b0;
    Reset = 1'b0;
    bus.read1 = 4'd15;
    #1;
    checks++; if (bus.dataRead1 !== 16'h0000) begin errors++; $display("FAIL rst_r15_cleared got=%h exp=%h", bus.dataRead1, 16'h0000); end
    bus.WriteEn = 1'b1;
    @(posedge Clock); #1;
    checks++; if (bus.dataWritten !== 16'h5555) begin errors++; $display("FAIL post_rst_wr got=%h exp=%h", bus.dataWritten, 16'h5555); end
    bus.WriteEn = 1'b0;
    @(negedge Clock);
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_write_disable();
    test_read_during_write();
    test_reg0_and_15();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
